addr_carry_look_ahead: RTL and testbench

//   Parameterised carry-lookahead adder: X + Y + carry-in -> (p_WIDTH+1)-bit sum.

---
 rtl/addr_carry_look_ahead.sv | 107 ++++++++++
 tb/tb_addr_carry_look_ahead.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_carry_look_ahead.sv
// Carry-lookahead adder: X + Y + carry-in, with the carry, propagate and generate
// vectors exported. Two-level lookahead (4-bit groups), all outputs registered.
module addr_carry_look_ahead #(
    parameter int unsigned p_WIDTH = 4
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic [p_WIDTH-1:0] iv_x,
    input  logic [p_WIDTH-1:0] iv_y,
    input  logic               iw_carry,
    output logic [p_WIDTH:0]   ov_carry,
    output logic [p_WIDTH:0]   ov_sum,
    output logic [p_WIDTH:0]   ov_cs,
    output logic [p_WIDTH:0]   ov_output
);

    localparam int unsigned GROUP = 4;
    localparam int unsigned NG    = (p_WIDTH + GROUP - 1) / GROUP;
    localparam int          W_I   = int'(p_WIDTH);
    localparam int          NG_I  = int'(NG);

    logic [p_WIDTH-1:0] p;
    logic [p_WIDTH-1:0] g;
    logic [NG-1:0]      grp_g;
    logic [NG-1:0]      grp_p;
    logic [NG:0]        grp_c;
    logic [p_WIDTH:0]   c;
    logic [p_WIDTH:0]   result_c;

    logic gp_run;
    logic lc_run;
    logic lc_acc;
    logic bc_run;
    logic bc_acc;

    assign p = iv_x ^ iv_y;
    assign g = iv_x & iv_y;

    // Group generate/propagate; the last group only spans the bits that exist.
    always_comb begin
        grp_g  = '0;
        grp_p  = '0;
        gp_run = 1'b0;
        for (int k = 0; k < NG_I; k++) begin
            gp_run = 1'b1;
            for (int j = ((4 * k + 3 < W_I) ? 3 : (W_I - 1 - 4 * k)); j >= 0; j--) begin
                grp_g[k] = grp_g[k] | (g[4 * k + j] & gp_run);
                gp_run   = gp_run & p[4 * k + j];
            end
            grp_p[k] = gp_run;
        end
    end

    // Second level: each group carry is a flat sum of products over lower groups.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = iw_carry;
        lc_run   = 1'b0;
        lc_acc   = 1'b0;
        for (int k = 0; k < NG_I; k++) begin
            lc_run = 1'b1;
            lc_acc = 1'b0;
            for (int j = k; j >= 0; j--) begin
                lc_acc = lc_acc | (grp_g[j] & lc_run);
                lc_run = lc_run & grp_p[j];
            end
            grp_c[k + 1] = lc_acc | (lc_run & iw_carry);
        end
    end

    // Bit carries inside each group, expanded from that group's carry-in.
    always_comb begin
        c      = '0;
        bc_run = 1'b0;
        bc_acc = 1'b0;
        for (int k = 0; k < NG_I; k++) begin
            for (int i = 0; (i < 4) && (4 * k + i < W_I); i++) begin
                bc_run = 1'b1;
                bc_acc = 1'b0;
                for (int j = i - 1; j >= 0; j--) begin
                    bc_acc = bc_acc | (g[4 * k + j] & bc_run);
                    bc_run = bc_run & p[4 * k + j];
                end
                c[4 * k + i] = bc_acc | (bc_run & grp_c[k]);
            end
        end
        c[p_WIDTH] = grp_c[NG];
    end

    assign result_c = {c[p_WIDTH], p ^ c[p_WIDTH-1:0]};

    // Output registers; reset clears them immediately.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ov_carry  <= '0;
            ov_sum    <= '0;
            ov_cs     <= '0;
            ov_output <= '0;
        end else begin
            ov_carry  <= c;
            ov_sum    <= {1'b0, p};
            ov_cs     <= {1'b0, g};
            ov_output <= result_c;
        end
    end

endmodule

// File: tb/tb_addr_carry_look_ahead.sv
// Self-checking bench for addr_carry_look_ahead: one instance per width 2..8,
// all fed the same (masked) operands, checked through a scoreboard queue.
module tb_addr_carry_look_ahead;

    typedef struct packed {
        logic [8:2][8:0] carry;
        logic [8:2][8:0] sum;
        logic [8:2][8:0] cs;
        logic [8:2][8:0] out;
    } exp_t;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic       ci;
        logic [2:0] carry;
        logic [2:0] sum;
        logic [2:0] cs;
        logic [2:0] out;
    } dv_t;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [7:0] y;
    logic       cin;

    logic [8:0] d_carry [2:8];
    logic [8:0] d_sum   [2:8];
    logic [8:0] d_cs    [2:8];
    logic [8:0] d_out   [2:8];

    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    for (genvar w = 2; w <= 8; w++) begin : g_dut
        logic [w:0] o_carry;
        logic [w:0] o_sum;
        logic [w:0] o_cs;
        logic [w:0] o_out;

        addr_carry_look_ahead #(.p_WIDTH(w)) u_dut (
            .iw_clk    (clk),
            .iw_rst    (rst),
            .iv_x      (x[w-1:0]),
            .iv_y      (y[w-1:0]),
            .iw_carry  (cin),
            .ov_carry  (o_carry),
            .ov_sum    (o_sum),
            .ov_cs     (o_cs),
            .ov_output (o_out)
        );

        assign d_carry[w] = 9'(o_carry);
        assign d_sum[w]   = 9'(o_sum);
        assign d_cs[w]    = 9'(o_cs);
        assign d_out[w]   = 9'(o_out);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain addition plus the ripple carry recurrence, per width.
    function automatic exp_t model(input logic [7:0] xa, input logic [7:0] ya, input logic ci);
        exp_t       e;
        logic [8:0] xm;
        logic [8:0] ym;
        logic       c;
        e = '0;
        for (int w = 2; w <= 8; w++) begin
            xm = 9'(xa & 8'((1 << w) - 1));
            ym = 9'(ya & 8'((1 << w) - 1));
            e.out[w] = xm + ym + 9'(ci);
            e.sum[w] = xm ^ ym;
            e.cs[w]  = xm & ym;
            c = ci;
            e.carry[w][0] = ci;
            for (int i = 0; i < w; i++) begin
                c = (xa[i] & ya[i]) | ((xa[i] ^ ya[i]) & c);
                e.carry[w][i + 1] = c;
            end
        end
        return e;
    endfunction

    task automatic test_reset;
        exp_t e;
        rst = 1'b0;
        x = 8'hA5; y = 8'h3C; cin = 1'b1;
        sb.push_back(model(x, y, cin));
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_bad++; $display("FAIL reset_preload scoreboard empty");
        end else begin
            e = sb.pop_front();
            for (int w = 2; w <= 8; w++) begin
                n_vec++;
                if (d_out[w] !== e.out[w]) begin
                    n_bad++; $display("FAIL preload_out w=%0d got %h want %h", w, d_out[w], e.out[w]);
                end
            end
        end
        // Assert mid-cycle: outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        for (int w = 2; w <= 8; w++) begin
            n_vec++;
            if ({d_carry[w], d_sum[w], d_cs[w], d_out[w]} !== 36'd0) begin
                n_bad++; $display("FAIL reset_async w=%0d got %h/%h/%h/%h want 0", w, d_carry[w], d_sum[w], d_cs[w], d_out[w]);
            end
        end
        @(posedge clk); #1;
        for (int w = 2; w <= 8; w++) begin
            n_vec++;
            if ({d_carry[w], d_sum[w], d_cs[w], d_out[w]} !== 36'd0) begin
                n_bad++; $display("FAIL reset_hold w=%0d got %h/%h/%h/%h want 0", w, d_carry[w], d_sum[w], d_cs[w], d_out[w]);
            end
        end
        // Release mid-cycle: still 0 until the next edge, which loads current inputs.
        x = 8'h5B; y = 8'hC7; cin = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int w = 2; w <= 8; w++) begin
            n_vec++;
            if (d_out[w] !== 9'd0) begin
                n_bad++; $display("FAIL reset_release w=%0d got %h want 0", w, d_out[w]);
            end
        end
        sb.push_back(model(x, y, cin));
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_bad++; $display("FAIL reset_first scoreboard empty");
        end else begin
            e = sb.pop_front();
            for (int w = 2; w <= 8; w++) begin
                n_vec++;
                if (d_out[w] !== e.out[w] || d_carry[w] !== e.carry[w] ||
                    d_sum[w] !== e.sum[w] || d_cs[w] !== e.cs[w]) begin
                    n_bad++;
                    $display("FAIL reset_first w=%0d got %h/%h/%h/%h want %h/%h/%h/%h", w,
                             d_carry[w], d_sum[w], d_cs[w], d_out[w],
                             e.carry[w], e.sum[w], e.cs[w], e.out[w]);
                end
            end
        end
    endtask

    task automatic test_directed;
        dv_t tbl [6];
        tbl = '{
            '{2'd3, 2'd1, 1'b0, 3'b110, 3'b010, 3'b001, 3'b100},
            '{2'd3, 2'd3, 1'b1, 3'b111, 3'b000, 3'b011, 3'b111},
            '{2'd2, 2'd1, 1'b1, 3'b111, 3'b011, 3'b000, 3'b100},
            '{2'd0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000},
            '{2'd0, 2'd0, 1'b1, 3'b001, 3'b000, 3'b000, 3'b001},
            '{2'd1, 2'd1, 1'b0, 3'b010, 3'b000, 3'b001, 3'b010}
        };
        for (int i = 0; i < 6; i++) begin
            x = {6'd0, tbl[i].x}; y = {6'd0, tbl[i].y}; cin = tbl[i].ci;
            @(posedge clk); #1;
            n_vec++;
            if (d_carry[2] !== 9'(tbl[i].carry)) begin
                n_bad++; $display("FAIL dir%0d_carry got %b want %b", i, d_carry[2], tbl[i].carry);
            end
            n_vec++;
            if (d_sum[2] !== 9'(tbl[i].sum)) begin
                n_bad++; $display("FAIL dir%0d_sum got %b want %b", i, d_sum[2], tbl[i].sum);
            end
            n_vec++;
            if (d_cs[2] !== 9'(tbl[i].cs)) begin
                n_bad++; $display("FAIL dir%0d_cs got %b want %b", i, d_cs[2], tbl[i].cs);
            end
            n_vec++;
            if (d_out[2] !== 9'(tbl[i].out)) begin
                n_bad++; $display("FAIL dir%0d_out got %b want %b", i, d_out[2], tbl[i].out);
            end
        end
    endtask

    // One operation per cycle, no bubbles; nrand > 0 switches to random 8-bit operands.
    task automatic test_back_to_back(input int nrand);
        exp_t e;
        int   total;
        total = (nrand > 0) ? nrand : 128 * 128 * 2;
        for (int n = 0; n < total; n++) begin
            if (nrand > 0) begin
                if (n == 0) begin
                    x = 8'hFF; y = 8'hFF; cin = 1'b1;
                end else begin
                    x = 8'($urandom_range(255)); y = 8'($urandom_range(255)); cin = 1'($urandom_range(1));
                end
            end else begin
                x = 8'(n >> 8); y = 8'((n >> 1) & 127); cin = 1'(n & 1);
            end
            sb.push_back(model(x, y, cin));
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_bad++; $display("FAIL b2b scoreboard empty at %0d", n);
            end else begin
                e = sb.pop_front();
                for (int w = 2; w <= 8; w++) begin
                    n_vec++;
                    if (d_out[w] !== e.out[w]) begin
                        n_bad++; $display("FAIL b2b_out w=%0d x=%h y=%h got %h want %h", w, x, y, d_out[w], e.out[w]);
                    end
                    n_vec++;
                    if (d_carry[w] !== e.carry[w]) begin
                        n_bad++; $display("FAIL b2b_carry w=%0d x=%h y=%h got %h want %h", w, x, y, d_carry[w], e.carry[w]);
                    end
                    n_vec++;
                    if (d_sum[w] !== e.sum[w]) begin
                        n_bad++; $display("FAIL b2b_sum w=%0d x=%h y=%h got %h want %h", w, x, y, d_sum[w], e.sum[w]);
                    end
                    n_vec++;
                    if (d_cs[w] !== e.cs[w]) begin
                        n_bad++; $display("FAIL b2b_cs w=%0d x=%h y=%h got %h want %h", w, x, y, d_cs[w], e.cs[w]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        x = '0; y = '0; cin = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_back_to_back(0);
        test_back_to_back(6000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
